// File: rtl/buffer_row_packer_if.sv
// Beat-stream, command and row-write signals of buffer_row_packer.
// Handshake: a beat moves on a rising edge where i_valid && o_ready; i_data is don't-care otherwise.
interface buffer_row_packer_if #(
    parameter int WIDTH = 384,
    parameter int IN_W  = 64,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              i_start;
    logic [ADDR_W-1:0] i_base;
    logic [ADDR_W:0]   i_rows;
    logic              i_valid;
    logic [IN_W-1:0]   i_data;
    logic              i_last;
    logic              o_ready;
    logic              o_we;
    logic [ADDR_W-1:0] o_addr_wr;
    logic [WIDTH-1:0]  o_data_wr;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_start, i_base, i_rows, i_valid, i_data, i_last,
        input  o_ready, o_we, o_addr_wr, o_data_wr, o_busy, o_done
    );

    modport slave (
        input  i_start, i_base, i_rows, i_valid, i_data, i_last,
        output o_ready, o_we, o_addr_wr, o_data_wr, o_busy, o_done
    );
endinterface

// File: rtl/buffer_row_packer.sv
// Packs WIDTH/IN_W input beats into one row and writes rows at wrapping sequential addresses.
// BUFFER_ROW_PACKER_LAST_EN: an accepted beat with i_last ends the transfer after a partial-row write.
module buffer_row_packer #(
    parameter int WIDTH = 384,
    parameter int IN_W  = 64,
    parameter int DEPTH = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    buffer_row_packer_if.slave  bus,
    output logic [1:0]          o_state
);
    localparam int BEATS  = WIDTH / IN_W;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ROWS_W = ADDR_W + 1;
    localparam int CNT_W  = $clog2(BEATS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ROWS_W-1:0] rows_q;
    logic [ROWS_W-1:0] row_cnt;
    logic [CNT_W-1:0]  beat_cnt;
    logic [WIDTH-1:0]  row_q;
    logic [WIDTH-1:0]  row_next;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  data_q;
    logic              accept;
    logic              row_full;
    logic              row_end;
    logic              final_row;
    logic              last_hit;
    logic              last_q;

`ifdef BUFFER_ROW_PACKER_LAST_EN
    assign last_hit = bus.i_last;

    // Remembers whether the row being written was closed by i_last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_q <= 1'b0;
        else if (state_q == S_IDLE)
            last_q <= 1'b0;
        else if (accept)
            last_q <= bus.i_last;
    end
`else
    logic unused_last;
    assign unused_last = bus.i_last;
    assign last_hit    = 1'b0;
    assign last_q      = 1'b0;
`endif

    assign accept    = (state_q == S_FILL) && bus.i_valid;
    assign row_full  = (beat_cnt == CNT_W'(BEATS - 1));
    assign row_end   = accept && (row_full || last_hit);
    assign final_row = (row_cnt == rows_q - ROWS_W'(1)) || last_q;

    // Current row with the incoming beat dropped into lane beat_cnt.
    always_comb begin
        row_next = row_q;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt == CNT_W'(k))
                row_next[k*IN_W +: IN_W] = bus.i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start)
                    state_d = (bus.i_rows == '0) ? S_DONE : S_FILL;
            end
            S_FILL: begin
                if (row_end)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = final_row ? S_DONE : S_FILL;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            base_q   <= '0;
            rows_q   <= '0;
            row_cnt  <= '0;
            beat_cnt <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        base_q   <= bus.i_base;
                        rows_q   <= bus.i_rows;
                        row_cnt  <= '0;
                        beat_cnt <= '0;
                        row_q    <= '0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        row_q    <= row_next;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    // Output registers are loaded as the row closes so they are valid during WRITE.
                    if (row_end) begin
                        data_q <= row_next;
                        addr_q <= base_q + row_cnt[ADDR_W-1:0];
                    end
                end
                S_WRITE: begin
                    beat_cnt <= '0;
                    row_q    <= '0;
                    if (!final_row)
                        row_cnt <= row_cnt + ROWS_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready   = (state_q == S_FILL);
    assign bus.o_we      = (state_q == S_WRITE);
    assign bus.o_done    = (state_q == S_DONE);
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_addr_wr = addr_q;
    assign bus.o_data_wr = data_q;
    assign o_state       = state_q;
endmodule

// File: tb/tb_buffer_row_packer.sv
// Randomized bench for buffer_row_packer: expected rows, addresses and timing come from a
// row/beat model built from the accepted beat list.
module tb_buffer_row_packer;
    localparam int WIDTH  = 384;
    localparam int IN_W   = 64;
    localparam int DEPTH  = 16;
    localparam int BEATS  = WIDTH / IN_W;
    localparam int ADDR_W = 4;
`ifdef BUFFER_ROW_PACKER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;

    buffer_row_packer_if #(.WIDTH(WIDTH), .IN_W(IN_W), .DEPTH(DEPTH)) bus ();

    buffer_row_packer #(.WIDTH(WIDTH), .IN_W(IN_W), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave),
        .o_state (state_dbg)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard storage
    logic [WIDTH-1:0]  exp_q[$];
    int                exp_addr_q[$];
    logic [WIDTH-1:0]  got_data_q[$];
    logic [ADDR_W-1:0] got_addr_q[$];
    int done_cnt = 0;
    int done_cyc = -1;
    int we_cyc = -1;
    int ready_in_we = 0;

    always @(negedge clk) begin
        if (bus.o_we) begin
            got_data_q.push_back(bus.o_data_wr);
            got_addr_q.push_back(bus.o_addr_wr);
            we_cyc = cyc;
            if (bus.o_ready) ready_in_we++;
        end
        if (bus.o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_idle_outputs(input string name);
        vectors++;
        if (bus.o_ready !== 1'b0 || bus.o_we !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ctrl: ready=%b we=%b busy=%b done=%b, expected all 0",
                     name, bus.o_ready, bus.o_we, bus.o_busy, bus.o_done);
        end
        vectors++;
        if (bus.o_addr_wr !== '0 || bus.o_data_wr !== '0) begin
            miscompares++;
            $display("FAIL %s regs: addr=%0h data=%0h, expected 0", name, bus.o_addr_wr, bus.o_data_wr);
        end
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0;
        bus.i_base  = '0;
        bus.i_rows  = '0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_last  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset_held");
        rst_n = 1'b1;
        bus.i_valid = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.o_ready !== 1'b0 || bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: ready=%b busy=%b, expected 0 0", bus.o_ready, bus.o_busy);
        end
        bus.i_valid = 1'b0;
    endtask

    // One full transfer; expected rows are rebuilt from the beats the handshake accepted.
    task automatic run_xfer(input string name, input int base, input int rows, input int gap_pct,
                            input int last_at, input bit seq_data, input bit poke_start);
        logic [IN_W-1:0]  beats[$];
        logic [WIDTH-1:0] row;
        logic [WIDTH-1:0] g;
        logic [ADDR_W-1:0] ga;
        int acc_n = 0;
        int budget = 0;
        int last_cyc = 0;
        int start_cyc, d0, ri0, n_rows, n_beats, idx, ea, r;

        got_data_q.delete();
        got_addr_q.delete();
        d0  = done_cnt;
        ri0 = ready_in_we;
        bus.i_base  = ADDR_W'(base);
        bus.i_rows  = (ADDR_W+1)'(rows);
        bus.i_start = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        #1;
        bus.i_start = 1'b0;
        vectors++;
        if (bus.o_busy !== 1'b1 || bus.o_ready !== (rows != 0)) begin
            miscompares++;
            $display("FAIL %s start_resp: busy=%b ready=%b, expected 1 %b", name, bus.o_busy, bus.o_ready, rows != 0);
        end

        while (done_cnt == d0 && budget < 4000) begin
            bus.i_valid = ($urandom_range(99) >= gap_pct);
            bus.i_data  = seq_data ? IN_W'(acc_n) : IN_W'({$urandom, $urandom});
            bus.i_last  = (acc_n == last_at);
            bus.i_start = poke_start && (acc_n == 2);
            if (bus.i_start) begin
                bus.i_base = ADDR_W'(base + 5);
                bus.i_rows = 1;
            end
            if (bus.i_valid && bus.o_ready) begin
                beats.push_back(bus.i_data);
                last_cyc = cyc;
                acc_n++;
            end
            @(negedge clk);
            #1;
            budget++;
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_start = 1'b0;

        vectors++;
        if (budget >= 4000) begin
            miscompares++;
            $display("FAIL %s timeout: no done after %0d cycles, expected done", name, budget);
        end

        n_beats = rows * BEATS;
        n_rows  = rows;
        if (LAST_EN && last_at >= 0 && last_at < rows * BEATS) begin
            n_beats = last_at + 1;
            n_rows  = last_at / BEATS + 1;
        end

        vectors++;
        if (acc_n != n_beats) begin
            miscompares++;
            $display("FAIL %s beats_accepted: got %0d expected %0d", name, acc_n, n_beats);
        end

        exp_q.delete();
        exp_addr_q.delete();
        for (r = 0; r < n_rows; r++) begin
            row = '0;
            for (int k = 0; k < BEATS; k++) begin
                idx = r * BEATS + k;
                if (idx < n_beats && idx < beats.size())
                    row[k*IN_W +: IN_W] = beats[idx];
            end
            exp_q.push_back(row);
            exp_addr_q.push_back((base + r) % DEPTH);
        end

        vectors++;
        if (got_data_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d expected %0d", name, got_data_q.size(), exp_q.size());
        end
        r = 0;
        while (exp_q.size() > 0 && got_data_q.size() > 0) begin
            row = exp_q.pop_front();
            ea  = exp_addr_q.pop_front();
            g   = got_data_q.pop_front();
            ga  = got_addr_q.pop_front();
            vectors++;
            if (ga !== ADDR_W'(ea)) begin
                miscompares++;
                $display("FAIL %s addr[%0d]: got %0d expected %0d", name, r, ga, ea);
            end
            vectors++;
            if (g !== row) begin
                miscompares++;
                $display("FAIL %s data[%0d]: got %0h expected %0h", name, r, g, row);
            end
            r++;
        end

        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0);
        end
        vectors++;
        if (ready_in_we != ri0) begin
            miscompares++;
            $display("FAIL %s ready_in_write: got %0d cycles expected 0", name, ready_in_we - ri0);
        end
        if (n_rows > 0) begin
            vectors++;
            if (we_cyc != last_cyc + 1 || done_cyc != last_cyc + 2) begin
                miscompares++;
                $display("FAIL %s tail_timing: we@%0d done@%0d, expected we@%0d done@%0d",
                         name, we_cyc, done_cyc, last_cyc + 1, last_cyc + 2);
            end
        end else begin
            vectors++;
            if (done_cyc != start_cyc + 1) begin
                miscompares++;
                $display("FAIL %s zero_done: done@%0d expected @%0d", name, done_cyc, start_cyc + 1);
            end
        end

        @(negedge clk);
        #1;
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s back_idle: busy=%b done=%b, expected 0 0", name, bus.o_busy, bus.o_done);
        end
    endtask

    task automatic test_single_row();
        run_xfer("single_row", 0, 1, 0, -1, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        run_xfer("wrap", 14, 4, 35, -1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_rows();
        run_xfer("zero_rows", 5, 0, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_xfer("start_ignored", 9, 2, 20, -1, 1'b0, 1'b1);
    endtask

    task automatic test_last();
        run_xfer("last_partial", 6, 3, 10, 2, 1'b0, 1'b0);
        run_xfer("last_full_row", 2, 3, 10, BEATS - 1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_xfer("b2b", int'($urandom_range(DEPTH - 1)), int'($urandom_range(4)),
                     int'($urandom_range(50)), -1, 1'b0, 1'b0);
        run_xfer("full_depth", 3, DEPTH, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        int acc_n = 0;
        int budget = 0;
        int d0;
        got_data_q.delete();
        got_addr_q.delete();
        d0 = done_cnt;
        bus.i_base  = 3;
        bus.i_rows  = 3;
        bus.i_start = 1'b1;
        @(negedge clk);
        #1;
        while (acc_n < BEATS + 3 && budget < 200) begin
            bus.i_valid = 1'b1;
            bus.i_data  = IN_W'({$urandom, $urandom});
            bus.i_start = (acc_n == 2);
            if (bus.i_start) begin
                bus.i_base = 11;
                bus.i_rows = 1;
            end
            if (bus.o_ready) acc_n++;
            @(negedge clk);
            #1;
            budget++;
        end
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;

        vectors++;
        if (got_addr_q.size() != 1 || (got_addr_q.size() > 0 && got_addr_q[0] !== ADDR_W'(3))) begin
            miscompares++;
            $display("FAIL abort_pre: writes=%0d first_addr=%0d, expected 1 write at 3",
                     got_addr_q.size(), (got_addr_q.size() > 0) ? int'(got_addr_q[0]) : -1);
        end
        vectors++;
        if (bus.o_busy !== 1'b1 || bus.o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_mid_fill: busy=%b ready=%b, expected 1 1", bus.o_busy, bus.o_ready);
        end

        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort_reset");
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        vectors++;
        if (got_data_q.size() != 1 || done_cnt != d0 || bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_after: writes=%0d done_pulses=%0d busy=%b, expected 1 0 0",
                     got_data_q.size(), done_cnt - d0, bus.o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_wrap();
        test_zero_rows();
        test_start_ignored();
        test_last();
        test_back_to_back();
        test_abort();
        test_single_row();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
